exp2_lms: RTL and testbench

- Antilog unit for the Lab->RGB return path. Converts log-domain LMS samples (unsigned Q3.13, the output format of the forward log2 stage) back to linear Q8.8.
- Computes 2^x using a fraction-mantissa LUT, optional linear interpolation and a barrel shift.
- 3-stage pipeline with valid/ready flow control. Sits between the inverse LMS matrix stage and the LMS->RGB matrix.

---
 rtl/lab_pkg.sv | 65 ++++++
 rtl/exp2_mant_lut.sv | 14 +
 rtl/exp2_lms.sv | 100 ++++++++++
 tb/tb_exp2_lms.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared Lab/LMS path definitions: Q-format widths, stage payload structs and
// the 2^(k/64) mantissa table, which is generated at elaboration time.
package lab_pkg;

  localparam int LOG_W      = 16;
  localparam int LOG_INT_W  = 3;
  localparam int LIN_W      = 16;
  localparam int LIN_FRAC_W = 8;
  localparam int MANT_W     = 17;
  localparam int LUT_IDX_W  = 6;
  localparam int LUT_N      = (1 << LUT_IDX_W) + 1;
  localparam int LO_W       = LOG_W - LOG_INT_W - LUT_IDX_W;
  localparam int IDX_W      = LUT_IDX_W + 1;

  typedef struct packed {
    logic [LOG_INT_W-1:0] integ;
    logic [LUT_IDX_W-1:0] idx;
    logic [LO_W-1:0]      lo;
  } s1_t;

  typedef struct packed {
    logic [LOG_INT_W-1:0] integ;
    logic [MANT_W-1:0]    m;
  } s2_t;

  function automatic logic [127:0] isqrt128(input logic [127:0] x);
    logic [127:0] num, res, b;
    num = x;
    res = '0;
    b   = 128'd1 << 126;
    for (int i = 0; i < 64; i++) begin
      if (num >= res + b) begin
        num = num - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return res;
  endfunction

  // Entry k = round(2^(k/64) * 2^15). Roots 2^(1/2^j) are built by repeated
  // integer square roots in Q60, so the table carries no hand-typed constants.
  function automatic logic [LUT_N*MANT_W-1:0] mant_tbl();
    logic [6:1][127:0]         root;
    logic [127:0]              acc;
    logic [LUT_N*MANT_W-1:0]   tbl;
    tbl     = '0;
    root[1] = isqrt128(128'd2 << 120);
    for (int j = 2; j <= 6; j++) root[j] = isqrt128(root[j-1] << 60);
    for (int k = 0; k < LUT_N; k++) begin
      acc = 128'd1 << 60;
      if (k == LUT_N - 1) acc = 128'd2 << 60;
      else
        for (int j = 1; j <= 6; j++)
          if (k[6-j]) acc = (acc * root[j]) >> 60;
      tbl[k*MANT_W +: MANT_W] = MANT_W'((acc + (128'd1 << 44)) >> 45);
    end
    return tbl;
  endfunction

  localparam logic [LUT_N*MANT_W-1:0] MANT_TBL = mant_tbl();

endpackage

// File: rtl/exp2_mant_lut.sv
// Combinational mantissa table lookup: idx (0..64) -> Q2.15 value of 2^(idx/64).
module exp2_mant_lut
  import lab_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [MANT_W-1:0] o_mant
);

  always_comb begin
    o_mant = '0;
    if (i_idx <= IDX_W'(LUT_N - 1)) o_mant = MANT_TBL[int'(i_idx)*MANT_W +: MANT_W];
  end

endmodule

// File: rtl/exp2_lms.sv
// Antilog for the Lab->RGB return path: Q3.13 log2 in, Q8.8 linear out, 3 stages.
// EXP2_INTERP_EN enables linear interpolation between table entries.
module exp2_lms
  import lab_pkg::*;
#(
  parameter int FRAC_LUT_BITS = 6,
  parameter int LAT           = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [LOG_W-1:0]  i_log,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [LIN_W-1:0]  o_lin
);

  localparam int SH_W     = MANT_W + (1 << LOG_INT_W) - 1;
  localparam int SCALE_SH = MANT_W - 2 - LIN_FRAC_W;
  localparam int RND      = 1 << (SCALE_SH - 1);

  logic              en, accept;
  logic [LAT:1]      vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic [LIN_W-1:0]  lin_q, lin_d;
  logic [MANT_W-1:0] mant_a, m;
  logic [SH_W-1:0]   shifted, rounded;
  logic [LIN_W-1:0]  scaled;

  assign en      = !vld_pipe_q[LAT] || i_ready;
  assign accept  = i_valid && en;
  assign o_ready = en;
  assign o_valid = vld_pipe_q[LAT];
  assign o_lin   = lin_q;

`ifdef EXP2_INTERP_EN
  logic [MANT_W-1:0]      mant_b, diff;
  logic [MANT_W+LO_W-1:0] prod;

  exp2_mant_lut u_lut_a (.i_idx({1'b0, s1_q.idx}),         .o_mant(mant_a));
  exp2_mant_lut u_lut_b (.i_idx({1'b0, s1_q.idx} + 7'd1),  .o_mant(mant_b));

  always_comb begin
    diff = mant_b - mant_a;
    prod = {{LO_W{1'b0}}, diff} * {{MANT_W{1'b0}}, s1_q.lo};
    m    = mant_a + prod[MANT_W+LO_W-1:LO_W];
  end
`else
  logic unused_lo;

  // Nearest-entry rounding: the top bit of lo picks idx or idx+1.
  exp2_mant_lut u_lut_a (
    .i_idx ({1'b0, s1_q.idx} + {{LUT_IDX_W{1'b0}}, s1_q.lo[LO_W-1]}),
    .o_mant(mant_a)
  );

  assign m         = mant_a;
  assign unused_lo = ^s1_q.lo[LO_W-2:0];
`endif

  always_comb begin
    shifted = {{(SH_W-MANT_W){1'b0}}, s2_q.m} << s2_q.integ;
    rounded = (shifted + SH_W'(RND)) >> SCALE_SH;
    scaled  = (|rounded[SH_W-1:LIN_W]) ? '1 : rounded[LIN_W-1:0];
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    lin_d      = lin_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[LAT-1:1], accept};
      s1_d.integ = i_log[LOG_W-1 -: LOG_INT_W];
      s1_d.idx   = i_log[LOG_W-LOG_INT_W-1 -: FRAC_LUT_BITS];
      s1_d.lo    = i_log[LOG_W-LOG_INT_W-FRAC_LUT_BITS-1:0];
      s2_d.integ = s1_q.integ;
      s2_d.m     = m;
      // o_lin moves only when a valid sample lands on the output
      if (vld_pipe_q[LAT-1]) lin_d = scaled;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      lin_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      lin_q      <= lin_d;
    end
  end

endmodule

// File: tb/tb_exp2_lms.sv
// Scoreboard bench for exp2_lms: driver pushes expected Q8.8 results, the
// output monitor pops and compares them, and also checks hold-under-stall.
module tb_exp2_lms;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic [15:0] i_log;
  logic        o_ready, o_valid;
  logic [15:0] o_lin;

  typedef struct { logic [15:0] lin; int cyc; } sb_ent_t;

  sb_ent_t     sb_q[$];
  sb_ent_t     mon_e;
  int          n_tests = 0, n_fail = 0;
  int          n_in = 0, n_out = 0, cyc = 0;
  int          tb_lut[0:64];
  bit          lat_chk = 1'b1, rnd_rdy = 1'b0, stall_prev = 1'b0;
  logic [15:0] held_lin = '0;

  exp2_lms dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_log(i_log), .o_valid(o_valid), .i_ready(i_ready), .o_lin(o_lin)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic tb_chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp2_model(input logic [15:0] x);
    longint m, r;
    int     sh, idx, lo;
    sh  = int'(x[15:13]);
    idx = int'(x[12:7]);
    lo  = int'(x[6:0]);
`ifdef EXP2_INTERP_EN
    m = tb_lut[idx] + (((tb_lut[idx+1] - tb_lut[idx]) * lo) / 128);
`else
    m = tb_lut[idx + lo / 64];
`endif
    r = ((m << sh) + 64) >> 7;
    if (r > 65535) r = 65535;
    return r[15:0];
  endfunction

  task automatic send(input logic [15:0] v, input logic [15:0] e);
    int n;
    n = 0;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_log   = v;
    @(negedge i_clk);
    while (!o_ready && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    if (o_ready) begin
      sb_q.push_back('{e, cyc});
      n_in++;
    end else tb_chk("accept", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (n) @(posedge i_clk);
  endtask

  always @(posedge i_clk) begin
    if (rnd_rdy) begin
      #1;
      i_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Output monitor: in-order delivery, latency and stall stability
  always @(negedge i_clk) begin
    if (i_rst) begin
      n_in       = n_in - sb_q.size();
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tb_chk("hold_vld", {31'd0, o_valid}, 32'd1);
        tb_chk("hold_lin", {16'd0, o_lin}, {16'd0, held_lin});
      end
      if (o_valid && !i_ready) tb_chk("stall_rdy", {31'd0, o_ready}, 32'd0);
      if (o_valid && i_ready) begin
        tb_chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          n_out++;
          tb_chk("lin", {16'd0, o_lin}, {16'd0, mon_e.lin});
          if (lat_chk) tb_chk("latency", cyc - mon_e.cyc, 32'd3);
        end
      end
      stall_prev = o_valid && !i_ready;
      held_lin   = o_lin;
    end
  end

  initial begin
    int n;
    for (int k = 0; k <= 64; k++) tb_lut[k] = $rtoi(2.0 ** (real'(k) / 64.0) * 32768.0 + 0.5);
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_log = '0;

    repeat (3) @(negedge i_clk);
    tb_chk("rst_vld", {31'd0, o_valid}, 32'd0);
    tb_chk("rst_lin", {16'd0, o_lin}, 32'd0);
    tb_chk("rst_rdy", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Single samples, i_ready held high
    send(16'h0000, 16'h0100); idle(5);
    send(16'h6000, 16'h0800); idle(5);
    send(16'hF000, 16'hB505); idle(5);
`ifdef EXP2_INTERP_EN
    send(16'h00C0, exp2_model(16'h00C0)); idle(5);
    send(16'hFFFF, exp2_model(16'hFFFF)); idle(5);
`else
    send(16'h00C0, 16'h0106); idle(5);
    send(16'hFFFF, 16'hFFFF); idle(5);
`endif

    // Backpressure with three samples in flight
    lat_chk = 1'b0;
    send(16'h2000, 16'h0200);
    send(16'h4000, 16'h0400);
    send(16'h6000, 16'h0800);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    n = 0;
    @(negedge i_clk);
    while (!o_valid && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    tb_chk("bp_vld", {31'd0, o_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge i_clk);
      tb_chk("bp_rdy", {31'd0, o_ready}, 32'd0);
      tb_chk("bp_lin", {16'd0, o_lin}, 32'h0200);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    idle(8);

    // Full-rate sweep of every input code
    lat_chk = 1'b1;
    for (int v = 0; v < 65536; v++) send(16'(v), exp2_model(16'(v)));
    idle(8);

    // Random valid/ready toggling
    lat_chk = 1'b0;
    rnd_rdy = 1'b1;
    for (int s = 0; s < 3000; s++) begin
      logic [15:0] v;
      while ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_log   = 16'($urandom);
      end
      v = 16'($urandom);
      send(v, exp2_model(v));
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    rnd_rdy = 1'b0;
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    tb_chk("rnd_drain", sb_q.size(), 32'd0);
    tb_chk("rnd_count", n_out, n_in);

    // Reset with three samples in flight
    lat_chk = 1'b1;
    send(16'h1000, exp2_model(16'h1000));
    send(16'h3000, exp2_model(16'h3000));
    send(16'h5000, exp2_model(16'h5000));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    tb_chk("mid_rst_vld", {31'd0, o_valid}, 32'd0);
    tb_chk("mid_rst_lin", {16'd0, o_lin}, 32'd0);
    idle(6);
    send(16'h0000, 16'h0100);
    idle(6);

    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    tb_chk("drain", sb_q.size(), 32'd0);
    tb_chk("count", n_out, n_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
